// File: rtl/bus_sequencer.sv
// ==== bus_sequencer: fetch/decode/execute control sequencer with programmer bus arbitration ====
// ==== Rev 1.0 ====
`default_nettype none

module bus_sequencer #(
  parameter int CNT_W = 8,
  parameter int SEL_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             GO,
  input  logic             PRGM,
  input  logic             PRGM_ADDR_STB,
  input  logic             PRGM_DATA_STB,
  input  logic [3:0]       IR_OPCODE,
  input  logic             ZF,
  output logic [SEL_W-1:0] SEL,
  output logic             PC_EN,
  output logic             PC_LD,
  output logic             MAR_LD,
  output logic             RAM_WE,
  output logic             IR_LD,
  output logic             A_LD,
  output logic             B_LD,
  output logic             OUT_LD,
  output logic             CPU_CLR,
  output logic [2:0]       ALU_OP,
  output logic             HLT,
  output logic [2:0]       T_STEP,
  output logic [CNT_W-1:0] INSTR_CNT
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PROG = 3'd1,
    S_T0   = 3'd2,
    S_T1   = 3'd3,
    S_T2   = 3'd4,
    S_T3   = 3'd5,
    S_T4   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [SEL_W-1:0] SRC_PC   = SEL_W'(1);
  localparam logic [SEL_W-1:0] SRC_RAM  = SEL_W'(2);
  localparam logic [SEL_W-1:0] SRC_IR   = SEL_W'(3);
  localparam logic [SEL_W-1:0] SRC_A    = SEL_W'(4);
  localparam logic [SEL_W-1:0] SRC_ALU  = SEL_W'(5);
  localparam logic [SEL_W-1:0] SRC_PRGM = SEL_W'(6);

  state_t           state;
  logic             clr_pend;
  logic             last_step;
  logic [CNT_W-1:0] instr_cnt;

  // IR is only loaded at the end of T1, so the opcode is consulted from T2 on.
  always_comb begin
    last_step = 1'b0;
    case (state)
      S_T2:    last_step = !(IR_OPCODE inside {OP_LDA, OP_ADD, OP_SUB, OP_STA});
      S_T3:    last_step = (IR_OPCODE == OP_LDA) || (IR_OPCODE == OP_STA);
      S_T4:    last_step = 1'b1;
      default: last_step = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      clr_pend  <= 1'b0;
      instr_cnt <= '0;
    end else begin
      clr_pend <= 1'b0;
      if (last_step) instr_cnt <= instr_cnt + CNT_W'(1);
      case (state)
        S_IDLE, S_HALT: begin
          if (PRGM) begin
            state <= S_PROG;
          end else if (GO) begin
            state    <= S_T0;
            clr_pend <= 1'b1;
          end
        end
        S_PROG:  if (!PRGM) state <= S_IDLE;
        S_T0:    state <= S_T1;
        S_T1:    state <= S_T2;
        S_T2: begin
          if (!last_step)                state <= S_T3;
          else if (IR_OPCODE == OP_HLT)  state <= S_HALT;
          else                           state <= S_T0;
        end
        S_T3:    state <= last_step ? S_T0 : S_T4;
        S_T4:    state <= S_T0;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the present state; RESET masks them so an interrupted step emits nothing.
  always_comb begin
    SEL       = '0;
    PC_EN     = 1'b0;
    PC_LD     = 1'b0;
    MAR_LD    = 1'b0;
    RAM_WE    = 1'b0;
    IR_LD     = 1'b0;
    A_LD      = 1'b0;
    B_LD      = 1'b0;
    OUT_LD    = 1'b0;
    CPU_CLR   = 1'b0;
    ALU_OP    = 3'b000;
    HLT       = 1'b0;
    T_STEP    = 3'd0;
    INSTR_CNT = RESET ? '0 : instr_cnt;
    if (!RESET) begin
      HLT     = (state == S_HALT);
      CPU_CLR = clr_pend;
      case (state)
        S_PROG: begin
          SEL    = SRC_PRGM;
          MAR_LD = PRGM_ADDR_STB;
          RAM_WE = PRGM_DATA_STB;
        end
        S_T0: begin
          SEL    = SRC_PC;
          MAR_LD = 1'b1;
        end
        S_T1: begin
          T_STEP = 3'd1;
          SEL    = SRC_RAM;
          IR_LD  = 1'b1;
          PC_EN  = 1'b1;
        end
        S_T2: begin
          T_STEP = 3'd2;
          case (IR_OPCODE)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin SEL = SRC_IR; MAR_LD = 1'b1; end
            OP_LDI: begin SEL = SRC_IR; A_LD = 1'b1; end
            OP_JMP: begin SEL = SRC_IR; PC_LD = 1'b1; end
            OP_JZ:  if (ZF) begin SEL = SRC_IR; PC_LD = 1'b1; end
            OP_OUT: begin SEL = SRC_A; OUT_LD = 1'b1; end
            default: ;
          endcase
        end
        S_T3: begin
          T_STEP = 3'd3;
          case (IR_OPCODE)
            OP_LDA:         begin SEL = SRC_RAM; A_LD = 1'b1; end
            OP_ADD, OP_SUB: begin SEL = SRC_RAM; B_LD = 1'b1; end
            OP_STA:         begin SEL = SRC_A; RAM_WE = 1'b1; end
            default: ;
          endcase
        end
        S_T4: begin
          T_STEP = 3'd4;
          SEL    = SRC_ALU;
          A_LD   = 1'b1;
          ALU_OP = (IR_OPCODE == OP_SUB) ? 3'b001 : 3'b000;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_sequencer.sv
// ==== tb_bus_sequencer: cycle-table and scoreboard bench for bus_sequencer ====
// ==== Rev 1.0 ====
`default_nettype none

module tb_bus_sequencer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1, GO = 1'b0, PRGM = 1'b0, PRGM_ADDR_STB = 1'b0, PRGM_DATA_STB = 1'b0, ZF = 1'b0;
  logic [3:0] IR_OPCODE = 4'h0;
  logic [3:0] SEL;
  logic       PC_EN, PC_LD, MAR_LD, RAM_WE, IR_LD, A_LD, B_LD, OUT_LD, CPU_CLR, HLT;
  logic [2:0] ALU_OP, T_STEP;
  logic [7:0] INSTR_CNT;

  bus_sequencer #(.CNT_W(8), .SEL_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .GO(GO), .PRGM(PRGM),
    .PRGM_ADDR_STB(PRGM_ADDR_STB), .PRGM_DATA_STB(PRGM_DATA_STB),
    .IR_OPCODE(IR_OPCODE), .ZF(ZF), .SEL(SEL),
    .PC_EN(PC_EN), .PC_LD(PC_LD), .MAR_LD(MAR_LD), .RAM_WE(RAM_WE),
    .IR_LD(IR_LD), .A_LD(A_LD), .B_LD(B_LD), .OUT_LD(OUT_LD),
    .CPU_CLR(CPU_CLR), .ALU_OP(ALU_OP), .HLT(HLT), .T_STEP(T_STEP), .INSTR_CNT(INSTR_CNT)
  );

  always #5 CLK = ~CLK;

  // Strobe vector order: PC_EN PC_LD MAR_LD RAM_WE IR_LD A_LD B_LD OUT_LD CPU_CLR HLT
  localparam logic [9:0] E = 10'h000, PCEN = 10'h200, PCLD = 10'h100, MAR = 10'h080, WE = 10'h040;
  localparam logic [9:0] IRL = 10'h020, AL = 10'h010, BL = 10'h008, OL = 10'h004, CLR = 10'h002, H = 10'h001;

  typedef struct {
    string      name;
    logic       rst, go, prgm, astb, dstb;
    logic [3:0] op;
    logic       zf;
    logic [3:0] sel;
    logic [9:0] stb;
    logic [2:0] alu, t;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   compared = 0, mismatched = 0;

  function automatic vec_t v(string n, logic rst, logic go, logic prgm, logic a, logic d,
                             logic [3:0] op, logic zf, logic [3:0] sel, logic [9:0] stb,
                             logic [2:0] alu, logic [2:0] t, logic [7:0] cnt);
    vec_t r;
    r.name = n; r.rst = rst; r.go = go; r.prgm = prgm; r.astb = a; r.dstb = d;
    r.op = op; r.zf = zf; r.sel = sel; r.stb = stb; r.alu = alu; r.t = t; r.cnt = cnt;
    return r;
  endfunction

  function automatic void add(string n, logic rst, logic go, logic prgm, logic a, logic d,
                              logic [3:0] op, logic zf, logic [3:0] sel, logic [9:0] stb,
                              logic [2:0] alu, logic [2:0] t, logic [7:0] cnt);
    vecs.push_back(v(n, rst, go, prgm, a, d, op, zf, sel, stb, alu, t, cnt));
  endfunction

  function automatic void fetch(string n, logic [3:0] op, logic prgm, logic clr, logic [7:0] cnt);
    add({n, "_t0"}, 0, 0, prgm, 0, 0, op, 0, 4'd1, MAR | (clr ? CLR : E), 3'd0, 3'd0, cnt);
    add({n, "_t1"}, 0, 0, prgm, 0, 0, op, 0, 4'd2, PCEN | IRL, 3'd0, 3'd1, cnt);
  endfunction

  // Drive one cycle of stimulus, queue its expectation, then check it mid-cycle.
  task automatic apply(input vec_t x);
    vec_t       e;
    logic [27:0] act, exp;
    @(posedge CLK);
    #1;
    RESET = x.rst; GO = x.go; PRGM = x.prgm; PRGM_ADDR_STB = x.astb; PRGM_DATA_STB = x.dstb;
    IR_OPCODE = x.op; ZF = x.zf;
    sb.push_back(x);
    @(negedge CLK);
    e   = sb.pop_front();
    act = {SEL, PC_EN, PC_LD, MAR_LD, RAM_WE, IR_LD, A_LD, B_LD, OUT_LD, CPU_CLR, HLT,
           ALU_OP, T_STEP, INSTR_CNT};
    exp = {e.sel, e.stb, e.alu, e.t, e.cnt};
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got sel=%0d stb=%b alu=%b t=%0d cnt=%0d, want sel=%0d stb=%b alu=%b t=%0d cnt=%0d",
               e.name, SEL, act[23:14], ALU_OP, T_STEP, INSTR_CNT, e.sel, e.stb, e.alu, e.t, e.cnt);
    end
  endtask

  initial begin
    int c;
    add("rst", 1, 0, 0, 0, 0, 4'h0, 0, 4'd0, E, 3'd0, 3'd0, 8'd0);
    add("rst", 1, 0, 0, 0, 0, 4'h0, 0, 4'd0, E, 3'd0, 3'd0, 8'd0);
    for (int i = 0; i < 10; i++) add("idle", 0, 0, 0, 0, 0, 4'h0, 0, 4'd0, E, 3'd0, 3'd0, 8'd0);
    add("prg_req",  0, 1, 1, 0, 0, 4'h0, 0, 4'd0, E,        3'd0, 3'd0, 8'd0);
    add("prog",     0, 1, 1, 0, 0, 4'h0, 0, 4'd6, E,        3'd0, 3'd0, 8'd0);
    add("prg_addr", 0, 0, 1, 1, 0, 4'h0, 0, 4'd6, MAR,      3'd0, 3'd0, 8'd0);
    add("prg_data", 0, 0, 1, 0, 1, 4'h0, 0, 4'd6, WE,       3'd0, 3'd0, 8'd0);
    add("prg_both", 0, 0, 1, 1, 1, 4'h0, 0, 4'd6, MAR | WE, 3'd0, 3'd0, 8'd0);
    add("prg_rel",  0, 0, 0, 0, 0, 4'h0, 0, 4'd6, E,        3'd0, 3'd0, 8'd0);
    add("idle2",    0, 0, 0, 0, 0, 4'h0, 0, 4'd0, E,        3'd0, 3'd0, 8'd0);
    add("go",       0, 1, 0, 0, 0, 4'h4, 0, 4'd0, E,        3'd0, 3'd0, 8'd0);
    fetch("ldi", 4'h4, 1, 1, 8'd0);
    add("ldi_t2",   0, 0, 1, 0, 0, 4'h4, 0, 4'd3, AL,   3'd0, 3'd2, 8'd0);
    fetch("out", 4'hE, 1, 0, 8'd1);
    add("out_t2",   0, 0, 0, 0, 0, 4'hE, 0, 4'd4, OL,   3'd0, 3'd2, 8'd1);
    fetch("add", 4'h1, 0, 0, 8'd2);
    add("add_t2",   0, 0, 0, 0, 0, 4'h1, 0, 4'd3, MAR,  3'd0, 3'd2, 8'd2);
    add("add_t3",   0, 0, 0, 0, 0, 4'h1, 0, 4'd2, BL,   3'd0, 3'd3, 8'd2);
    add("add_t4",   0, 0, 0, 0, 0, 4'h1, 0, 4'd5, AL,   3'd0, 3'd4, 8'd2);
    fetch("sub", 4'h2, 0, 0, 8'd3);
    add("sub_t2",   0, 0, 0, 0, 0, 4'h2, 0, 4'd3, MAR,  3'd0, 3'd2, 8'd3);
    add("sub_t3",   0, 0, 0, 0, 0, 4'h2, 0, 4'd2, BL,   3'd0, 3'd3, 8'd3);
    add("sub_t4",   0, 0, 0, 0, 0, 4'h2, 0, 4'd5, AL,   3'd1, 3'd4, 8'd3);
    fetch("jz1", 4'h6, 0, 0, 8'd4);
    add("jz1_t2",   0, 0, 0, 0, 0, 4'h6, 1, 4'd3, PCLD, 3'd0, 3'd2, 8'd4);
    fetch("jz0", 4'h6, 0, 0, 8'd5);
    add("jz0_t2",   0, 0, 0, 0, 0, 4'h6, 0, 4'd0, E,    3'd0, 3'd2, 8'd5);
    fetch("sta", 4'h3, 0, 0, 8'd6);
    add("sta_t2",   0, 0, 0, 0, 0, 4'h3, 0, 4'd3, MAR,  3'd0, 3'd2, 8'd6);
    add("sta_t3",   0, 0, 0, 0, 0, 4'h3, 0, 4'd4, WE,   3'd0, 3'd3, 8'd6);
    fetch("lda", 4'h0, 0, 0, 8'd7);
    add("lda_t2",   0, 0, 0, 0, 0, 4'h0, 0, 4'd3, MAR,  3'd0, 3'd2, 8'd7);
    add("lda_t3",   0, 0, 0, 0, 0, 4'h0, 0, 4'd2, AL,   3'd0, 3'd3, 8'd7);
    fetch("jmp", 4'h5, 0, 0, 8'd8);
    add("jmp_t2",   0, 0, 0, 0, 0, 4'h5, 0, 4'd3, PCLD, 3'd0, 3'd2, 8'd8);
    fetch("nop", 4'h7, 0, 0, 8'd9);
    add("nop_t2",   0, 0, 0, 0, 0, 4'h7, 0, 4'd0, E,    3'd0, 3'd2, 8'd9);
    fetch("hlt", 4'hF, 0, 0, 8'd10);
    add("hlt_t2",   0, 0, 0, 0, 0, 4'hF, 0, 4'd0, E,    3'd0, 3'd2, 8'd10);
    add("halt",     0, 0, 0, 0, 0, 4'hF, 0, 4'd0, H,    3'd0, 3'd0, 8'd11);
    add("halt",     0, 0, 0, 0, 0, 4'hF, 0, 4'd0, H,    3'd0, 3'd0, 8'd11);
    add("halt_go",  0, 1, 0, 0, 0, 4'h3, 0, 4'd0, H,    3'd0, 3'd0, 8'd11);
    fetch("restart", 4'h3, 0, 1, 8'd11);
    add("rs_t2",    0, 0, 0, 0, 0, 4'h3, 0, 4'd3, MAR,  3'd0, 3'd2, 8'd11);
    add("rst_t3",   1, 0, 0, 0, 0, 4'h3, 0, 4'd0, E,    3'd0, 3'd0, 8'd0);
    add("post_rst", 0, 0, 0, 0, 0, 4'h3, 0, 4'd0, E,    3'd0, 3'd0, 8'd0);

    foreach (vecs[i]) apply(vecs[i]);

    // Counter wrap: 257 NOPs from a fresh start, counter must roll 255 -> 0.
    apply(v("wrap_go", 0, 1, 0, 0, 0, 4'h7, 0, 4'd0, E, 3'd0, 3'd0, 8'd0));
    c = 0;
    for (int i = 0; i < 257; i++) begin
      apply(v("wrap_t0", 0, 0, 0, 0, 0, 4'h7, 0, 4'd1, MAR | ((i == 0) ? CLR : E), 3'd0, 3'd0, 8'(c)));
      apply(v("wrap_t1", 0, 0, 0, 0, 0, 4'h7, 0, 4'd2, PCEN | IRL, 3'd0, 3'd1, 8'(c)));
      apply(v("wrap_t2", 0, 0, 0, 0, 0, 4'h7, 0, 4'd0, E, 3'd0, 3'd2, 8'(c)));
      c = (c + 1) & 255;
    end
    apply(v("wrap_end", 0, 0, 0, 0, 0, 4'h7, 0, 4'd1, MAR, 3'd0, 3'd0, 8'd1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
